load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 load/store unit: single-beat bus request with byte lanes, alignment check and ack timeout.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        MemWrite,
  input  logic [1:0]  Store,
  input  logic [2:0]  Load,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic [31:0] baddr_q, baddr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] bwdata_q, bwdata_d;
  logic [1:0]  ld_size_q, ld_size_d;
  logic        ld_signed_q, ld_signed_d;
  logic [1:0]  ld_lo_q, ld_lo_d;

  // Access size of the incoming instruction: 0 byte, 1 half, 2 word
  logic [1:0]  size;
  logic        sign_ext;
  logic        misalign_now;
  logic [3:0]  be_now;
  logic [31:0] wfmt_now;

  always_comb begin
    size     = 2'd2;
    sign_ext = 1'b0;
    if (MemWrite) begin
      case (Store)
        2'b00:   size = 2'd0;
        2'b01:   size = 2'd1;
        default: size = 2'd2;
      endcase
    end else begin
      case (Load)
        3'b000:  begin size = 2'd0; sign_ext = 1'b1; end
        3'b001:  begin size = 2'd1; sign_ext = 1'b1; end
        3'b011:  size = 2'd0;
        3'b100:  size = 2'd1;
        default: size = 2'd2;
      endcase
    end

    misalign_now = ((size == 2'd1) && addr[0]) ||
                   ((size == 2'd2) && (addr[1:0] != 2'b00));

    case (size)
      2'd0: begin
        be_now   = 4'b0001 << addr[1:0];
        wfmt_now = {4{wdata[7:0]}};
      end
      2'd1: begin
        be_now   = addr[1] ? 4'b1100 : 4'b0011;
        wfmt_now = {2{wdata[15:0]}};
      end
      default: begin
        be_now   = 4'b1111;
        wfmt_now = wdata;
      end
    endcase
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    case (ld_lo_q)
      2'd0:    ld_byte = bus_rdata[7:0];
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = ld_lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (ld_size_q)
      2'd0:    ld_ext = {{24{ld_signed_q & ld_byte[7]}}, ld_byte};
      2'd1:    ld_ext = {{16{ld_signed_q & ld_half[15]}}, ld_half};
      default: ld_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    mis_d       = mis_q;
    err_d       = err_q;
    we_d        = we_q;
    baddr_d     = baddr_q;
    be_d        = be_q;
    bwdata_d    = bwdata_q;
    ld_size_d   = ld_size_q;
    ld_signed_d = ld_signed_q;
    ld_lo_d     = ld_lo_q;
    stall       = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_en) begin
          stall = 1'b1;
          if (misalign_now) begin
            mis_d   = 1'b1;
            rdata_d = 32'h0;
            state_d = DONE;
          end else begin
            we_d        = MemWrite;
            baddr_d     = {addr[31:2], 2'b00};
            be_d        = be_now;
            bwdata_d    = wfmt_now;
            ld_size_d   = size;
            ld_signed_d = sign_ext;
            ld_lo_d     = addr[1:0];
            cnt_d       = 8'h0;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus_ack) begin
          if (!we_q) rdata_d = ld_ext;
          state_d = DONE;
        end else if (cnt_q == LAST_CNT) begin
          err_d   = 1'b1;
          rdata_d = 32'h0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        mis_d   = 1'b0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'h0;
      rdata_q     <= 32'h0;
      mis_q       <= 1'b0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      baddr_q     <= 32'h0;
      be_q        <= 4'b0000;
      bwdata_q    <= 32'h0;
      ld_size_q   <= 2'd0;
      ld_signed_q <= 1'b0;
      ld_lo_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      mis_q       <= mis_d;
      err_q       <= err_d;
      we_q        <= we_d;
      baddr_q     <= baddr_d;
      be_q        <= be_d;
      bwdata_q    <= bwdata_d;
      ld_size_q   <= ld_size_d;
      ld_signed_q <= ld_signed_d;
      ld_lo_q     <= ld_lo_d;
    end
  end

  assign bus_req    = (state_q == REQ);
  assign rdata      = rdata_q;
  assign misaligned = mis_q;
  assign bus_err    = err_q;
  assign bus_we     = we_q;
  assign bus_addr   = baddr_q;
  assign bus_be     = be_q;
  assign bus_wdata  = bwdata_q;

endmodule
